// File: rtl/tdm_sample_sequencer.sv
// TDM sample sequencer: settles after each mux channel switch, runs one ADC handshake per slot
// and publishes a coherent four-channel frame once the CH3 slot completes a full capture mask.
module tdm_sample_sequencer #(
   parameter int unsigned DATA_W      = 12,
   parameter int unsigned SETTLE_CYC  = 8,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              CH1,
   input  logic              CH2,
   input  logic              CH3,
   input  logic              CH4,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              adc_done,
   input  logic              err_clr,
   output logic              adc_start,
   output logic [DATA_W-1:0] ch1_data,
   output logic [DATA_W-1:0] ch2_data,
   output logic [DATA_W-1:0] ch3_data,
   output logic [DATA_W-1:0] ch4_data,
   output logic              frame_valid,
   output logic              miss_err,
   output logic              onehot_err,
   output logic              timeout_err
);

   localparam int unsigned CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [1:0]       IDX_CH3      = 2'd2;

   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_START, S_WAIT, S_HOLD} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         prev_q, prev_d;
   logic [1:0]         act_q, act_d;
   logic [3:0]         mask_q, mask_d;
   logic [DATA_W-1:0]  shadow_q [4];
   logic [DATA_W-1:0]  shadow_d [4];
   logic [DATA_W-1:0]  pub_q [4];
   logic [DATA_W-1:0]  pub_d [4];
   logic               fv_q, fv_d;
   logic               miss_q, miss_d;
   logic               onehot_q, onehot_d;
   logic               tmo_q, tmo_d;

   logic [3:0] sel;
   logic       sel_ok, sw;
   logic [1:0] sel_idx;
   logic [3:0] mask_new;
   logic       miss_set, onehot_set, tmo_set;

   assign sel    = {CH4, CH3, CH2, CH1};
   assign sel_ok = $onehot(sel);
   assign sw     = sel_ok && (sel != prev_q);

   always_comb begin
      sel_idx = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (sel[i]) sel_idx = 2'(i);
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      prev_d     = sel;
      act_d      = act_q;
      mask_d     = mask_q;
      shadow_d   = shadow_q;
      pub_d      = pub_q;
      fv_d       = 1'b0;
      miss_set   = 1'b0;
      onehot_set = 1'b0;
      tmo_set    = 1'b0;
      mask_new   = mask_q | (4'b0001 << act_q);

      // Priority: bad select, then channel switch, then per-state progress.
      if (!sel_ok) begin
         onehot_set = 1'b1;
         state_d    = S_IDLE;
         cnt_d      = '0;
         prev_d     = '0;
      end else if (sw) begin
         if (state_q inside {S_SETTLE, S_START, S_WAIT}) miss_set = 1'b1;
         state_d = S_SETTLE;
         cnt_d   = '0;
         act_d   = sel_idx;
      end else begin
         unique case (state_q)
            S_SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  state_d = S_START;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_START: begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end
            S_WAIT: begin
               if (adc_done) begin
                  shadow_d[act_q] = adc_data;
                  state_d         = S_HOLD;
                  if (act_q == IDX_CH3) begin
                     mask_d = '0;
                     if (mask_new == 4'b1111) begin
                        pub_d = shadow_d;
                        fv_d  = 1'b1;
                     end
                  end else begin
                     mask_d = mask_new;
                  end
               end else if (cnt_q == TIMEOUT_LAST) begin
                  tmo_set = 1'b1;
                  state_d = S_HOLD;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end

      miss_d   = miss_set   | (miss_q   & ~err_clr);
      onehot_d = onehot_set | (onehot_q & ~err_clr);
      tmo_d    = tmo_set    | (tmo_q    & ~err_clr);
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         prev_q   <= '0;
         act_q    <= '0;
         mask_q   <= '0;
         shadow_q <= '{default: '0};
         pub_q    <= '{default: '0};
         fv_q     <= 1'b0;
         miss_q   <= 1'b0;
         onehot_q <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         prev_q   <= prev_d;
         act_q    <= act_d;
         mask_q   <= mask_d;
         shadow_q <= shadow_d;
         pub_q    <= pub_d;
         fv_q     <= fv_d;
         miss_q   <= miss_d;
         onehot_q <= onehot_d;
         tmo_q    <= tmo_d;
      end
   end

   assign adc_start   = (state_q == S_START);
   assign ch1_data    = pub_q[0];
   assign ch2_data    = pub_q[1];
   assign ch3_data    = pub_q[2];
   assign ch4_data    = pub_q[3];
   assign frame_valid = fv_q;
   assign miss_err    = miss_q;
   assign onehot_err  = onehot_q;
   assign timeout_err = tmo_q;

endmodule

// File: tb/tb_tdm_sample_sequencer.sv
// Bench for tdm_sample_sequencer: table-driven channel sweeps with a frame scoreboard,
// plus directed sequences for aborted slots, timeout, bad selects and mid-conversion reset.
module tb_tdm_sample_sequencer;

   localparam int unsigned DW = 12;
   localparam int unsigned SC = 8;
   localparam int unsigned TC = 64;

   localparam logic [3:0] SEL_CH1 = 4'b0001;
   localparam logic [3:0] SEL_CH2 = 4'b0010;
   localparam logic [3:0] SEL_CH3 = 4'b0100;
   localparam logic [3:0] SEL_CH4 = 4'b1000;

   logic          clk = 1'b0;
   logic          RST;
   logic          CH1, CH2, CH3, CH4;
   logic [DW-1:0] adc_data;
   logic          adc_done;
   logic          err_clr;
   logic          adc_start;
   logic [DW-1:0] ch1_data, ch2_data, ch3_data, ch4_data;
   logic          frame_valid, miss_err, onehot_err, timeout_err;

   always #5 clk = ~clk;

   tdm_sample_sequencer #(
      .DATA_W      (DW),
      .SETTLE_CYC  (SC),
      .TIMEOUT_CYC (TC)
   ) dut (
      .clk         (clk),
      .RST         (RST),
      .CH1         (CH1),
      .CH2         (CH2),
      .CH3         (CH3),
      .CH4         (CH4),
      .adc_data    (adc_data),
      .adc_done    (adc_done),
      .err_clr     (err_clr),
      .adc_start   (adc_start),
      .ch1_data    (ch1_data),
      .ch2_data    (ch2_data),
      .ch3_data    (ch3_data),
      .ch4_data    (ch4_data),
      .frame_valid (frame_valid),
      .miss_err    (miss_err),
      .onehot_err  (onehot_err),
      .timeout_err (timeout_err)
   );

   typedef logic [4*DW-1:0] frame_t;   // {ch4, ch3, ch2, ch1}
   typedef struct {
      logic [3:0]    sel;
      logic [DW-1:0] val;
      int unsigned   exp_lat;
      bit            exp_frame;
   } step_t;

   int unsigned   n_tests = 0;
   int unsigned   n_fail  = 0;
   int unsigned   frames_seen = 0;
   frame_t        sb[$];
   logic [DW-1:0] sh  [4];
   logic [DW-1:0] pub [4];
   step_t         tbl [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (RST === 1'b0 && frame_valid === 1'b1) begin
         frame_t f;
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_valid_unexpected: got 1 expected 0");
         end else begin
            f = sb.pop_front();
            frames_seen++;
            chk("frame_ch1", 32'(ch1_data), 32'(f[DW-1:0]));
            chk("frame_ch2", 32'(ch2_data), 32'(f[2*DW-1:DW]));
            chk("frame_ch3", 32'(ch3_data), 32'(f[3*DW-1:2*DW]));
            chk("frame_ch4", 32'(ch4_data), 32'(f[4*DW-1:3*DW]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_sel(input logic [3:0] s);
      {CH4, CH3, CH2, CH1} = s;
   endtask

   function automatic int unsigned idx_of(input logic [3:0] s);
      case (s)
         SEL_CH1: return 0;
         SEL_CH2: return 1;
         SEL_CH3: return 2;
         default: return 3;
      endcase
   endfunction

   // Returns the number of edges after the first edge following the call at which adc_start is seen.
   task automatic wait_start(output int unsigned lat);
      lat = 999;
      for (int unsigned n = 1; n <= 40 && lat == 999; n++) begin
         tick();
         if (adc_start) lat = n - 1;
      end
   endtask

   // Called just after adc_start becomes visible; adc_done is sampled dly edges later.
   task automatic adc_respond(input int unsigned dly, input logic [DW-1:0] val);
      repeat (dly - 1) tick();
      adc_done = 1'b1;
      adc_data = val;
      tick();
      adc_done = 1'b0;
      adc_data = '0;
   endtask

   task automatic chk_pub(input string tag);
      chk({tag, "_ch1"}, 32'(ch1_data), 32'(pub[0]));
      chk({tag, "_ch2"}, 32'(ch2_data), 32'(pub[1]));
      chk({tag, "_ch3"}, 32'(ch3_data), 32'(pub[2]));
      chk({tag, "_ch4"}, 32'(ch4_data), 32'(pub[3]));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_adc_start"},   32'(adc_start),   32'd0);
      chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
      chk({tag, "_miss_err"},    32'(miss_err),    32'd0);
      chk({tag, "_onehot_err"},  32'(onehot_err),  32'd0);
      chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
      chk_pub(tag);
   endtask

   task automatic run_step(input step_t s);
      int unsigned lat;
      drive_sel(s.sel);
      wait_start(lat);
      chk("start_latency", lat, s.exp_lat);
      sh[idx_of(s.sel)] = s.val;
      if (s.exp_frame) begin
         pub = sh;
         sb.push_back({sh[3], sh[2], sh[1], sh[0]});
      end
      adc_respond(5, s.val);
      chk_pub("step_pub");
      repeat (26) tick();
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned lat;
      int unsigned tl;
      bit          seen;

      tbl[0] = '{SEL_CH4, 12'h111, SC, 1'b0};
      tbl[1] = '{SEL_CH1, 12'h222, SC, 1'b0};
      tbl[2] = '{SEL_CH2, 12'h333, SC, 1'b0};
      tbl[3] = '{SEL_CH3, 12'h444, SC, 1'b1};
      tbl[4] = '{SEL_CH4, 12'h5A5, SC, 1'b0};
      tbl[5] = '{SEL_CH1, 12'h6B6, SC, 1'b0};
      tbl[6] = '{SEL_CH2, 12'h7C7, SC, 1'b0};
      tbl[7] = '{SEL_CH3, 12'h8D8, SC, 1'b1};
      sh  = '{default: '0};
      pub = '{default: '0};

      RST = 1'b1; adc_done = 1'b0; adc_data = '0; err_clr = 1'b0;
      drive_sel(4'b0000);
      repeat (3) tick();
      chk_reset_outputs("reset");

      // Two full sweeps: published frame only moves on each CH3 completion.
      RST = 1'b0;
      for (int i = 0; i < 8; i++) run_step(tbl[i]);

      // Slot aborted by a switch that coincides with adc_done: CH1 never captured, so no frame.
      run_step('{SEL_CH4, 12'h901, SC, 1'b0});
      drive_sel(SEL_CH1);
      wait_start(lat);
      chk("abort_ch1_latency", lat, SC);
      repeat (2) tick();
      drive_sel(SEL_CH2);
      adc_done = 1'b1;
      adc_data = 12'hBAD;
      tick();
      adc_done = 1'b0;
      adc_data = '0;
      chk("miss_err_set", 32'(miss_err), 32'd1);
      wait_start(lat);
      chk("abort_ch2_latency", lat + 1, SC);
      sh[1] = 12'h902;
      adc_respond(5, 12'h902);
      repeat (20) tick();
      run_step('{SEL_CH3, 12'h903, SC, 1'b0});
      chk("miss_err_sticky", 32'(miss_err), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("miss_err_cleared", 32'(miss_err), 32'd0);

      // Timeout counted from the edge that samples adc_start.
      drive_sel(SEL_CH4);
      wait_start(lat);
      chk("timeout_start_latency", lat, SC);
      tl = 999;
      for (int unsigned k = 1; k <= 100 && tl == 999; k++) begin
         tick();
         if (timeout_err) tl = k - 1;
      end
      chk("timeout_latency", tl, TC);
      adc_done = 1'b1;
      adc_data = 12'hEEE;
      tick();
      adc_done = 1'b0;
      adc_data = '0;
      run_step('{SEL_CH1, 12'hA01, SC, 1'b0});
      chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("timeout_err_cleared", 32'(timeout_err), 32'd0);

      // Non-one-hot selects.
      drive_sel(4'b0000);
      tick();
      chk("onehot_err_zero", 32'(onehot_err), 32'd1);
      drive_sel(4'b0110);
      seen = 1'b0;
      repeat (20) begin
         tick();
         if (adc_start) seen = 1'b1;
      end
      chk("bad_sel_no_start", 32'(seen), 32'd0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("onehot_set_beats_clear", 32'(onehot_err), 32'd1);
      drive_sel(SEL_CH4);
      wait_start(lat);
      chk("restore_latency", lat, SC);
      adc_respond(5, 12'hC04);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("onehot_err_cleared", 32'(onehot_err), 32'd0);

      // Reset in WAIT; a late adc_done in the following SETTLE is ignored.
      drive_sel(SEL_CH1);
      wait_start(lat);
      chk("rst_case_latency", lat, SC);
      repeat (2) tick();
      RST = 1'b1;
      tick();
      sh  = '{default: '0};
      pub = '{default: '0};
      chk_reset_outputs("mid_reset");
      RST = 1'b0;
      tick();
      adc_done = 1'b1;
      adc_data = 12'hDDD;
      tick();
      adc_done = 1'b0;
      adc_data = '0;
      wait_start(lat);
      chk("post_reset_latency", lat + 2, SC);
      adc_respond(5, 12'h0F1);
      chk_pub("post_reset_pub");
      repeat (5) tick();

      chk("scoreboard_empty", sb.size(), 0);
      chk("frames_seen", frames_seen, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
